// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the single-cycle control decoders and data memory.
// Opcode constants cover instruction bits [6:2]; ALU selects are 4-bit codes.
package rv_ctrl_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/rv_dmem.sv
// Word-organised data memory: combinational gated read, clocked write,
// whole-array clear while the active-low reset is asserted.
module rv_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_read ? mem_q[idx] : 32'h0;

endmodule

// File: rtl/rv_ctrl_dmem.sv
// Single-cycle RISC-V main control + ALU control decode + data memory.
// Define RV_CTRL_OPIMM_EN to decode OP-IMM (opcode 00100) with ALUOp 11.
module rv_ctrl_dmem
    import rv_ctrl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_sel,
    output logic [31:0] rdata
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R:      ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R};
            OP_LOAD:   ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALUOP_ADD};
            OP_STORE:  ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALUOP_ADD};
            OP_BRANCH: ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_SUB};
`ifdef RV_CTRL_OPIMM_EN
            OP_OPIMM:  ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALUOP_I};
`endif
            default:   ctrl = '0;
        endcase
    end

    assign branch     = ctrl.branch;
    assign mem_read   = ctrl.mem_read;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign mem_write  = ctrl.mem_write;
    assign alu_src    = ctrl.alu_src;
    assign reg_write  = ctrl.reg_write;
    assign alu_op     = ctrl.alu_op;

    // Immediate forms carry immediate bits in inst[30], so only shifts honour it there
    always_comb begin
        alu_sel = ALU_ADD;
        case (ctrl.alu_op)
            ALUOP_ADD: alu_sel = ALU_ADD;
            ALUOP_SUB: alu_sel = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_sel = (funct7_5 && ctrl.alu_op == ALUOP_R) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_sel = ALU_SLL;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b011:  alu_sel = ALU_SLTU;
                    3'b100:  alu_sel = ALU_XOR;
                    3'b101:  alu_sel = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_sel = ALU_OR;
                    default: alu_sel = ALU_AND;
                endcase
            end
        endcase
    end

    // Byte offset and bits above the array are dropped: aligned, wrapping access
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    rv_dmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (ctrl.mem_read),
        .mem_write (ctrl.mem_write),
        .idx       (addr[AW+1:2]),
        .wdata     (wdata),
        .rdata     (rdata)
    );

endmodule

// File: tb/tb_rv_ctrl_dmem.sv
// Bench for rv_ctrl_dmem: directed literal checks followed by random traffic
// compared every cycle against a table-driven control model and an array memory.
module tb_rv_ctrl_dmem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  opcode = 5'b11111;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_sel;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    logic [31:0] mdl [64];

    rv_ctrl_dmem dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .addr       (addr),
        .wdata      (wdata),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_sel    (alu_sel),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    // Control word {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    function automatic logic [7:0] exp_ctrl(input logic [4:0] op);
        case (op)
            5'b01100: return 8'b0000_0110;
            5'b00000: return 8'b0110_1100;
            5'b01000: return 8'b0001_1000;
            5'b11000: return 8'b1000_0001;
`ifdef RV_CTRL_OPIMM_EN
            5'b00100: return 8'b0000_1111;
`endif
            default:  return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input logic [1:0] aop, input logic [2:0] f3, input logic f7);
        logic [3:0] by_f3 [8];
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0110;
        by_f3 = '{4'b0010, 4'b1000, 4'b1101, 4'b1111, 4'b0111, 4'b1001, 4'b0001, 4'b0000};
        if (f7 && f3 == 3'b101) return 4'b1010;
        if (f7 && f3 == 3'b000 && aop == 2'b10) return 4'b0110;
        return by_f3[f3];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        opcode = op; funct3 = f3; funct7_5 = f7; addr = a; wdata = wd;
    endtask

    // Model memory update at the active edge
    always @(posedge clk) begin
        logic [7:0] c;
        c = exp_ctrl(opcode);
        if (reset && c[4]) mdl[addr[7:2]] <= wdata;
    end

    // Compare process
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [7:0] c;
            c = exp_ctrl(opcode);
            chk("ctrl", {24'h0, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op},
                {24'h0, c});
            chk("alu_sel", {28'h0, alu_sel}, {28'h0, exp_alu(c[1:0], funct3, funct7_5)});
            chk("rdata", rdata, c[6] ? mdl[addr[7:2]] : 32'h0);
        end
    end

    initial begin
        logic [31:0] r;
        logic [4:0]  ops [5];
        ops = '{5'b01100, 5'b00000, 5'b01000, 5'b11000, 5'b00100};
        clear_model();
        cmp_en = 1'b1;

        // Reset state: memory cleared, load reads zero
        drive(5'b00000, 3'b000, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        @(posedge clk); #1; reset = 1'b1;

        drive(5'b01100, 3'b000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("radd_ctrl", {29'h0, reg_write, alu_op}, {29'h0, 1'b1, 2'b10});
        chk("radd_src", {31'h0, alu_src}, 32'h0);
        chk("radd_sel", {28'h0, alu_sel}, 32'h2);
        drive(5'b01100, 3'b000, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        chk("rsub_sel", {28'h0, alu_sel}, 32'h6);

        drive(5'b11000, 3'b000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("br_ctrl", {27'h0, branch, mem_write, reg_write, alu_op}, {27'h0, 5'b10001});
        chk("br_sel", {28'h0, alu_sel}, 32'h6);

        drive(5'b01000, 3'b000, 1'b0, 32'h8, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("st_rdata", rdata, 32'h0);
        drive(5'b00000, 3'b000, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        chk("ld_flags", {30'h0, mem_read, mem_to_reg}, 32'h3);
        chk("ld_rdata", rdata, 32'hDEAD_BEEF);

        drive(5'b01000, 3'b000, 1'b0, 32'h4, 32'h1234_5678);
        drive(5'b00000, 3'b000, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        chk("ld_wrap", rdata, 32'h1234_5678);
        drive(5'b00000, 3'b000, 1'b0, 32'h7, 32'h0);
        @(negedge clk);
        chk("ld_misalign", rdata, 32'h1234_5678);

        // Async reset between edges, then a blocked store
        drive(5'b00000, 3'b000, 1'b0, 32'h4, 32'h0);
        #2;
        reset = 1'b0; clear_model();
        #1;
        chk("async_clear", rdata, 32'h0);
        drive(5'b01000, 3'b000, 1'b0, 32'h4, 32'hFFFF_FFFF);
        drive(5'b00000, 3'b000, 1'b0, 32'h4, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("blocked_store", rdata, 32'h0);

        drive(5'b11111, 3'b000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("unk_ctrl", {24'h0, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}, 32'h0);

        drive(5'b00100, 3'b000, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
`ifdef RV_CTRL_OPIMM_EN
        chk("opimm_ctrl", {28'h0, alu_sel}, 32'h2);
        chk("opimm_rw", {30'h0, reg_write, alu_src}, 32'h3);
`else
        chk("opimm_off", {30'h0, reg_write, alu_src}, 32'h0);
`endif

        // Random traffic, concentrated on a few words to get read-after-write hits
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            r = $urandom();
            opcode = (r[2:0] < 3'd5) ? ops[r[2:0]] : 5'($urandom());
            funct3 = 3'($urandom());
            funct7_5 = 1'($urandom());
            r = $urandom();
            addr = (r & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            wdata = $urandom();
            if ($urandom_range(0, 40) == 0) begin
                #2;
                reset = 1'b0;
                clear_model();
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
